param_pic_core: RTL and testbench

- Clocked, parametrised successor to the 8259-style interrupt controller.
- Supports NUM_IRQ request lines (2..32) with per-channel edge/level trigger, mask, fully-nested or rotating priority, normal or auto EOI, and a programmable vector base.
- Integrates IRR, ISR, priority resolution and the acknowledge sequencer in one synchronous block.
- A simple register port replaces the ICW/OCW byte sequencing.

---
 rtl/param_pic_core.sv | 230 +++++++++++++++++++++++
 tb/tb_param_pic_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_pic_core.sv
// Parametrised 8259-style interrupt controller: IRR/ISR, mask, edge/level trigger,
// nested or rotating priority, normal/auto EOI and a memory-mapped register port.
module param_pic_core #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               int_out,
  input  logic               inta,
  output logic               vector_valid,
  output logic [VEC_W-1:0]   vector
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [5:0] N6 = 6'(NUM_IRQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IRQ - 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_VEC  = 2'd2;

  logic [NUM_IRQ-1:0] irq_s_q, irr_q, isr_q, mask_q, trig_q;
  logic [NUM_IRQ-1:0] irr_d, isr_d, mask_d, trig_d;
  logic [VEC_W-1:0]   vbase_q, vbase_d, vec_q, vec_d;
  logic               rot_q, rot_d, aeoi_q, aeoi_d;
  logic [IW-1:0]      last_q, last_d, idx_q, idx_d;
  logic [1:0]         state_q, state_d;
  logic               ack_ok_q, ack_ok_d, int_q, int_d, vv_q, vv_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [5:0]         base_s, cand_rank_s, isr_rank_s;
  logic [IW-1:0]      cand_idx_s, isr_top_idx_s, eoi_idx_s;
  logic               cand_ok_s, eoi_hit_s;
  logic [NUM_IRQ-1:0] ack_set_s, aeoi_clr_s, eoi_clr_s;
  logic               unused_wdata_s;

  // Distance from the top-priority position of the first set bit; N6 means none set.
  function automatic logic [5:0] first_rank(input logic [NUM_IRQ-1:0] v, input logic [5:0] base);
    logic [5:0] r;
    logic [5:0] j;
    r = N6;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      j = base + 6'(k);
      if (j >= N6) j = j - N6;
      if (v[j[IW-1:0]]) r = 6'(k);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rank_to_idx(input logic [5:0] rank, input logic [5:0] base);
    logic [5:0] s;
    s = base + rank;
    if (s >= N6) s = s - N6;
    return s[IW-1:0];
  endfunction

  assign unused_wdata_s = ^wdata;

  always_comb begin
    base_s = 6'd0;
    if (rot_q) base_s = (last_q == LAST_IDX) ? 6'd0 : 6'(last_q) + 6'd1;
    cand_rank_s   = first_rank(irr_q & ~mask_q, base_s);
    isr_rank_s    = first_rank(isr_q, base_s);
    cand_idx_s    = rank_to_idx(cand_rank_s, base_s);
    isr_top_idx_s = rank_to_idx(isr_rank_s, base_s);
    // A candidate only interrupts when it strictly outranks everything in service.
    cand_ok_s     = (cand_rank_s < isr_rank_s);
  end

  always_comb begin
    state_d   = state_q;
    int_d     = 1'b0;
    vv_d      = 1'b0;
    vec_d     = vec_q;
    idx_d     = idx_q;
    ack_ok_d  = ack_ok_q;
    ack_set_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (cand_ok_s) begin
          int_d   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (inta) begin
          state_d = ST_VEC;
          vv_d    = 1'b1;
          if (cand_ok_s) begin
            idx_d                 = cand_idx_s;
            ack_ok_d              = 1'b1;
            ack_set_s[cand_idx_s] = 1'b1;
          end else begin
            idx_d    = LAST_IDX;
            ack_ok_d = 1'b0;
          end
          vec_d = vbase_q + VEC_W'(idx_d);
        end else if (cand_ok_s) begin
          int_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    aeoi_clr_s = '0;
    if (state_q == ST_VEC && aeoi_q && ack_ok_q) aeoi_clr_s = NUM_IRQ'(1) << idx_q;
    else aeoi_clr_s = '0;
    eoi_idx_s = '0;
    eoi_hit_s = 1'b0;
    if (wr_en && addr == 3'd3) begin
      if (wdata[5]) begin
        if ({1'b0, wdata[4:0]} < N6) begin
          eoi_idx_s = wdata[IW-1:0];
          eoi_hit_s = isr_q[eoi_idx_s];
        end else begin
          eoi_hit_s = 1'b0;
        end
      end else if (isr_rank_s != N6) begin
        eoi_idx_s = isr_top_idx_s;
        eoi_hit_s = 1'b1;
      end else begin
        eoi_hit_s = 1'b0;
      end
    end else begin
      eoi_hit_s = 1'b0;
    end
    eoi_clr_s = eoi_hit_s ? (NUM_IRQ'(1) << eoi_idx_s) : '0;

    // Same-cycle ack on a bit wins over its EOI; edge requests re-arm even mid-ack.
    isr_d = (isr_q & ~eoi_clr_s & ~aeoi_clr_s) | ack_set_s;
    irr_d = (trig_q & irq_in) |
            (~trig_q & ((irr_q & ~(ack_set_s & ~trig_q)) | (irq_in & ~irq_s_q)));

    last_d = last_q;
    if (rot_q && (aeoi_clr_s != '0)) last_d = idx_q;
    else if (rot_q && eoi_hit_s) last_d = eoi_idx_s;
    else last_d = last_q;

    mask_d  = mask_q;
    trig_d  = trig_q;
    vbase_d = vbase_q;
    rot_d   = rot_q;
    aeoi_d  = aeoi_q;
    if (wr_en) begin
      case (addr)
        3'd0: begin
          rot_d  = wdata[0];
          aeoi_d = wdata[1];
        end
        3'd1:    mask_d  = wdata[NUM_IRQ-1:0];
        3'd2:    vbase_d = wdata[VEC_W-1:0];
        3'd6:    trig_d  = wdata[NUM_IRQ-1:0];
        default: mask_d  = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end

    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        3'd0:    rdata_d = {30'd0, aeoi_q, rot_q};
        3'd1:    rdata_d = 32'(mask_q);
        3'd2:    rdata_d = 32'(vbase_q);
        3'd4:    rdata_d = 32'(irr_q);
        3'd5:    rdata_d = 32'(isr_q);
        3'd6:    rdata_d = 32'(trig_q);
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_s_q  <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      mask_q   <= '1;
      trig_q   <= '0;
      vbase_q  <= '0;
      rot_q    <= 1'b0;
      aeoi_q   <= 1'b0;
      last_q   <= LAST_IDX;
      idx_q    <= '0;
      state_q  <= ST_IDLE;
      ack_ok_q <= 1'b0;
      int_q    <= 1'b0;
      vv_q     <= 1'b0;
      vec_q    <= '0;
      rdata_q  <= 32'd0;
    end else begin
      irq_s_q  <= irq_in;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      mask_q   <= mask_d;
      trig_q   <= trig_d;
      vbase_q  <= vbase_d;
      rot_q    <= rot_d;
      aeoi_q   <= aeoi_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      ack_ok_q <= ack_ok_d;
      int_q    <= int_d;
      vv_q     <= vv_d;
      vec_q    <= vec_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata        = rdata_q;
  assign int_out      = int_q;
  assign vector_valid = vv_q;
  assign vector       = vec_q;

endmodule

// File: tb/tb_param_pic_core.sv
// Directed bench for param_pic_core: an 8-channel instance for the main scenarios
// and a 32-channel instance for vector wrap and reset during the vector cycle.
module tb_param_pic_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, rd_en, inta, int_out, vector_valid;
  logic [7:0]  irq_in, vector;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;

  logic        rst_n_b, wr_b, rd_b, inta_b, int_b, vv_b;
  logic [31:0] irq_b, wdata_b, rdata_b;
  logic [2:0]  addr_b;
  logic [7:0]  vec_b;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [31:0] v;

  param_pic_core #(.NUM_IRQ(8), .VEC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .int_out(int_out), .inta(inta),
    .vector_valid(vector_valid), .vector(vector)
  );

  param_pic_core #(.NUM_IRQ(32), .VEC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .irq_in(irq_b), .wr_en(wr_b), .rd_en(rd_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .int_out(int_b), .inta(inta_b),
    .vector_valid(vv_b), .vector(vec_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a, output logic [31:0] r);
    addr = a; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    r = rdata;
  endtask

  task automatic wr_bt(input logic [2:0] a, input logic [31:0] d);
    addr_b = a; wdata_b = d; wr_b = 1'b1;
    step(1);
    wr_b = 1'b0;
  endtask

  task automatic rd_bt(input logic [2:0] a, output logic [31:0] r);
    addr_b = a; rd_b = 1'b1;
    step(1);
    rd_b = 1'b0;
    r = rdata_b;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; inta = 1'b0; irq_in = 8'h00;
    addr = 3'd0; wdata = 32'd0;
    rst_n_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; inta_b = 1'b0; irq_b = 32'd0;
    addr_b = 3'd0; wdata_b = 32'd0;
    step(2);
    chk("rst_int", 32'(int_out), 32'd0);
    chk("rst_vv", 32'(vector_valid), 32'd0);
    chk("rst_vec", 32'(vector), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1; rst_n_b = 1'b1;
    rd_a(3'd1, v); chk("rst_mask", v, 32'h0000_00FF);
    rd_a(3'd5, v); chk("rst_isr", v, 32'd0);

    // Edge request on channel 3, vector base 0x20
    wr_a(3'd1, 32'd0);
    wr_a(3'd2, 32'h20);
    irq_in = 8'h08; step(1);
    chk("t1_int_t1", 32'(int_out), 32'd0);
    irq_in = 8'h00; step(1);
    chk("t1_int_t2", 32'(int_out), 32'd1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t1_vv", 32'(vector_valid), 32'd1);
    chk("t1_vec", 32'(vector), 32'h23);
    chk("t1_int_vec", 32'(int_out), 32'd0);
    step(1);
    chk("t1_vv_once", 32'(vector_valid), 32'd0);
    rd_a(3'd5, v); chk("t1_isr", v, 32'h08);
    rd_a(3'd4, v); chk("t1_irr", v, 32'h00);

    // Nesting under ISR[3]
    irq_in = 8'h20; step(1); irq_in = 8'h00; step(2);
    chk("t2_no_int5", 32'(int_out), 32'd0);
    irq_in = 8'h02; step(1); irq_in = 8'h00; step(1);
    chk("t2_int1", 32'(int_out), 32'd1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t2_vec1", 32'(vector), 32'h21);
    step(1);
    rd_a(3'd5, v); chk("t2_isr_0a", v, 32'h0A);
    wr_a(3'd3, 32'h0);
    rd_a(3'd5, v); chk("t2_isr_nseoi", v, 32'h08);
    wr_a(3'd3, 32'h0);
    step(1);
    chk("t2_int5", 32'(int_out), 32'd1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t2_vec5", 32'(vector), 32'h25);
    step(1);
    wr_a(3'd3, 32'h2D);
    rd_a(3'd5, v); chk("t2_eoi_oob", v, 32'h20);
    wr_a(3'd3, 32'h25);
    rd_a(3'd5, v); chk("t2_isr_seoi", v, 32'h00);

    // Rotating priority with auto EOI
    wr_a(3'd0, 32'h3);
    irq_in = 8'h05; step(1); irq_in = 8'h00; step(1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t3_vec0", 32'(vector), 32'h20);
    step(1);
    rd_a(3'd5, v); chk("t3_isr_aeoi", v, 32'h00);
    chk("t3_int2", 32'(int_out), 32'd1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t3_vec2", 32'(vector), 32'h22);
    step(1);
    irq_in = 8'h03; step(1); irq_in = 8'h00; step(1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t3_vec0_after2", 32'(vector), 32'h20);
    step(1);
    irq_in = 8'h01; step(1); irq_in = 8'h00; step(1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t3_vec1_first", 32'(vector), 32'h21);
    step(2);
    chk("t3_int0", 32'(int_out), 32'd1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t3_vec0_last", 32'(vector), 32'h20);
    step(1);
    wr_a(3'd0, 32'h0);
    rd_a(3'd5, v); chk("t3_isr_end", v, 32'h00);

    // Level request withdrawn before acknowledge
    wr_a(3'd6, 32'h10);
    irq_in = 8'h10; step(2);
    chk("t4_int_lvl", 32'(int_out), 32'd1);
    irq_in = 8'h00; step(2);
    chk("t4_int_drop", 32'(int_out), 32'd0);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t4_no_vv", 32'(vector_valid), 32'd0);
    step(1);
    chk("t4_no_vv2", 32'(vector_valid), 32'd0);

    // Spurious acknowledge: request gone when inta is sampled
    irq_in = 8'h10; step(2);
    chk("t5_int", 32'(int_out), 32'd1);
    irq_in = 8'h00; step(1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("t5_vv", 32'(vector_valid), 32'd1);
    chk("t5_vec", 32'(vector), 32'h27);
    step(1);
    rd_a(3'd5, v); chk("t5_isr", v, 32'h00);
    rd_a(3'd4, v); chk("t5_irr", v, 32'h00);

    // Register map edges
    wr_a(3'd4, 32'hFF);
    rd_a(3'd4, v); chk("reg_irr_ro", v, 32'h00);
    rd_a(3'd3, v); chk("reg_eoi_rd", v, 32'h00);
    wr_a(3'd7, 32'hFFFF_FFFF);
    rd_a(3'd7, v); chk("reg_rsvd", v, 32'h00);
    wr_a(3'd2, 32'h1FF);
    rd_a(3'd2, v); chk("reg_vbase_w", v, 32'hFF);
    rd_a(3'd6, v); chk("reg_trig", v, 32'h10);

    // 32 channels: vector wrap, then reset in the vector cycle
    wr_bt(3'd1, 32'd0);
    wr_bt(3'd2, 32'hF0);
    rd_bt(3'd2, v); chk("b_vbase", v, 32'hF0);
    irq_b = 32'h8000_0000; step(1);
    chk("b_int_t1", 32'(int_b), 32'd0);
    irq_b = 32'd0; step(1);
    chk("b_int_t2", 32'(int_b), 32'd1);
    inta_b = 1'b1; step(1); inta_b = 1'b0;
    chk("b_vv", 32'(vv_b), 32'd1);
    chk("b_vec_wrap", 32'(vec_b), 32'h0F);
    rst_n_b = 1'b0; step(1);
    chk("b_rst_vv", 32'(vv_b), 32'd0);
    chk("b_rst_vec", 32'(vec_b), 32'd0);
    chk("b_rst_int", 32'(int_b), 32'd0);
    chk("b_rst_rdata", rdata_b, 32'd0);
    rst_n_b = 1'b1;
    rd_bt(3'd1, v); chk("b_rst_mask", v, 32'hFFFF_FFFF);
    rd_bt(3'd5, v); chk("b_rst_isr", v, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
